// File: rtl/manch_pkg.sv
// Shared Manchester link definitions: frame FSM states, sync shape, bit encoding
// and parity helpers used by the transmitter (and the planned decoder rewrite).
package manch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY,
        GAP
    } state_t;

    localparam int unsigned SYNC_HALF      = 6;
    localparam int unsigned SYNC_HIGH_HALF = 3;
    localparam logic        BIT1_FIRST_HALF = 1'b1;

    // Zero-extension is harmless: padding zeros do not change the XOR.
    function automatic logic odd_parity(input logic [31:0] data);
        return ~(^data);
    endfunction

    // Line level for one half of an encoded bit.
    function automatic logic half_level(input logic data_bit, input logic second_half);
        return (data_bit ~^ BIT1_FIRST_HALF) ^ second_half;
    endfunction

endpackage

// File: rtl/manch_halfbit_tick.sv
// Half-bit timer: free-runs 0..HALF_BIT_CLKS-1 while enabled and flags the terminal count.
module manch_halfbit_tick #(
    parameter int unsigned HALF_BIT_CLKS = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic TICK
);

    localparam int unsigned CNT_W = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_BIT_CLKS - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || !EN) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign TICK = EN && (cnt == TERM);

endmodule

// File: rtl/manch_tx.sv
// Manchester frame transmitter: accepts a word over valid/ready and sends
// sync violation, data MSB first, odd parity, then an idle gap.
module manch_tx
    import manch_pkg::*;
#(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned HALF_BIT_CLKS = 8,
    parameter int unsigned GAP_HALF      = 4,
    parameter logic        IDLE_LEVEL    = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              MANCH,
    output logic              TX_EN,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned MAX_A = (2 * DATA_W > SYNC_HALF) ? 2 * DATA_W : SYNC_HALF;
    localparam int unsigned MAX_B = (GAP_HALF > MAX_A) ? GAP_HALF : MAX_A;
    localparam int unsigned IDX_W = $clog2(MAX_B + 1);

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic              par, par_next;
    logic              manch_next, tx_en_next, busy_next, done_next, ready_next;
    logic              tick;

    manch_halfbit_tick #(
        .HALF_BIT_CLKS(HALF_BIT_CLKS)
    ) u_tick (
        .CLK (CLK),
        .RST (RST),
        .EN  (state != IDLE),
        .TICK(tick)
    );

    // State, datapath and registered line outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            MANCH     <= IDLE_LEVEL;
            TX_EN     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            DIN_READY <= 1'b1;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            shreg     <= shreg_next;
            par       <= par_next;
            MANCH     <= manch_next;
            TX_EN     <= tx_en_next;
            BUSY      <= busy_next;
            DONE      <= done_next;
            DIN_READY <= ready_next;
        end
    end

    // Next state and next output values; outputs lag the state by one cycle.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        shreg_next = shreg;
        par_next   = par;
        manch_next = IDLE_LEVEL;
        tx_en_next = 1'b0;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (DIN_VALID) begin
                    shreg_next = DIN;
                    par_next   = odd_parity(32'(DIN));
                    idx_next   = '0;
                    state_next = SYNC;
                end
            end

            SYNC: begin
                manch_next = (idx < IDX_W'(SYNC_HIGH_HALF));
                tx_en_next = 1'b1;
                if (tick) begin
                    if (idx == IDX_W'(SYNC_HALF - 1)) begin
                        idx_next   = '0;
                        state_next = DATA;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end

            DATA: begin
                manch_next = half_level(shreg[DATA_W-1], idx[0]);
                tx_en_next = 1'b1;
                if (tick) begin
                    if (idx[0]) begin
                        shreg_next = shreg << 1;
                    end
                    if (idx == IDX_W'(2 * DATA_W - 1)) begin
                        idx_next   = '0;
                        state_next = PARITY;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end

            PARITY: begin
                manch_next = half_level(par, idx[0]);
                tx_en_next = 1'b1;
                if (tick) begin
                    if (idx[0]) begin
                        done_next  = 1'b1;
                        idx_next   = '0;
                        state_next = (GAP_HALF > 0) ? GAP : IDLE;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end

            GAP: begin
                if (tick) begin
                    if (idx == IDX_W'(GAP_HALF - 1)) begin
                        idx_next   = '0;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end

            default: begin
                idx_next   = '0;
                state_next = IDLE;
            end
        endcase

        // Ready/busy follow the next state so ready drops right after an accept.
        ready_next = (state_next == IDLE);
        busy_next  = (state_next != IDLE);
    end

endmodule

// File: tb/tb_manch_tx.sv
// Scoreboard bench for manch_tx: accepted words are queued, each transmitted
// frame is captured from MANCH/TX_EN, decoded and checked against the queue.
module tb_manch_tx;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned HALF       = 4;
    localparam int unsigned GAP        = 2;
    localparam int unsigned FRAME_CLKS = (8 + 2 * DATA_W) * HALF;

    typedef struct {
        logic [DATA_W-1:0] word;
        int                acc;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic [DATA_W-1:0] DIN;
    logic              DIN_VALID;
    logic              DIN_READY;
    logic              MANCH;
    logic              TX_EN;
    logic              BUSY;
    logic              DONE;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    logic samples [0:199];
    int   len = 0;
    int   first_cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   last_done_cyc = 0;
    int   idle_bad = 0;
    int   stray_done = 0;
    bit   mon_on = 1'b0;
    bit   aborted = 1'b0;

    manch_tx #(
        .DATA_W       (DATA_W),
        .HALF_BIT_CLKS(HALF),
        .GAP_HALF     (GAP),
        .IDLE_LEVEL   (1'b0)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .DIN      (DIN),
        .DIN_VALID(DIN_VALID),
        .DIN_READY(DIN_READY),
        .MANCH    (MANCH),
        .TX_EN    (TX_EN),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decode one captured frame and compare it with the oldest queued word.
    task automatic frame_end();
        exp_t              e;
        logic [23:0]       sync_w;
        logic [DATA_W-1:0] dec;
        logic [7:0]        par_w;
        logic [7:0]        par_exp;
        int                glitch;
        int                viol;
        int                h;
        if (aborted) begin
            check("abort_no_done", 32'(done_cnt), 32'd0);
            aborted = 1'b0;
            return;
        end
        if (sb.size() == 0) begin
            check("unexpected_frame", 32'(len), 32'd0);
            return;
        end
        e = sb.pop_front();
        check("frame_len", 32'(len), 32'(FRAME_CLKS));
        if (len != int'(FRAME_CLKS)) return;
        check("start_latency", 32'(first_cyc - e.acc), 32'd1);
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_cycle", 32'(done_cyc - e.acc), 32'(FRAME_CLKS));
        sync_w = '0;
        for (int i = 0; i < 24; i++) sync_w = {sync_w[22:0], samples[i]};
        check("sync", 32'(sync_w), 32'h00FFF000);
        glitch = 0;
        for (int hb = 0; hb < 40; hb++)
            for (int k = 1; k < int'(HALF); k++)
                if (samples[hb*HALF+k] !== samples[hb*HALF]) glitch++;
        check("glitch", 32'(glitch), 32'd0);
        dec  = '0;
        viol = 0;
        for (int b = 0; b < int'(DATA_W); b++) begin
            h = 6 + 2 * b;
            if (samples[h*HALF] === samples[(h+1)*HALF]) viol++;
            dec = {dec[DATA_W-2:0], samples[h*HALF]};
        end
        check("data_violation", 32'(viol), 32'd0);
        check("data", 32'(dec), 32'(e.word));
        par_w = '0;
        for (int i = 152; i < 160; i++) par_w = {par_w[6:0], samples[i]};
        par_exp = (~^e.word) ? 8'hF0 : 8'h0F;
        check("parity_wave", 32'(par_w), 32'(par_exp));
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (mon_on) begin
            if (TX_EN === 1'b1) begin
                if (len == 0) first_cyc = cyc;
                if (len < 200) samples[len] = MANCH;
                len++;
                if (DONE === 1'b1) begin
                    done_cnt++;
                    done_cyc      = cyc;
                    last_done_cyc = cyc;
                end
            end else begin
                if (MANCH !== 1'b0) idle_bad++;
                if (DONE !== 1'b0) stray_done++;
                if (len > 0) begin
                    frame_end();
                    len      = 0;
                    done_cnt = 0;
                end
            end
        end
    end

    task automatic send(input logic [DATA_W-1:0] w, input bit keep, output int acc);
        int   n;
        exp_t e;
        @(negedge CLK);
        DIN       = w;
        DIN_VALID = 1'b1;
        n = 0;
        while (DIN_READY !== 1'b1 && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        check("accept_timeout", 32'(n < 1000), 32'd1);
        acc    = cyc + 1;
        e.word = w;
        e.acc  = acc;
        sb.push_back(e);
        @(negedge CLK);
        check("ready_drop", 32'({DIN_READY, BUSY}), 32'b01);
        if (!keep) DIN_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || BUSY !== 1'b0) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("idle_timeout", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run still active at %0t, expected end well before", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a1;
        int a2;
        RST       = 1'b1;
        DIN       = '0;
        DIN_VALID = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("reset_outputs", 32'({MANCH, TX_EN, BUSY, DIN_READY, DONE}), 32'b00010);
        end
        RST    = 1'b0;
        mon_on = 1'b1;
        @(negedge CLK);
        check("post_reset", 32'({MANCH, TX_EN, BUSY, DIN_READY, DONE}), 32'b00010);

        // Single frame, parity 1.
        send(16'hA5F0, 1'b0, a1);
        wait_idle();

        // Parity 0.
        send(16'h0001, 1'b0, a1);
        wait_idle();

        // Back-to-back with valid held high.
        send(16'h1234, 1'b1, a1);
        send(16'hFFFF, 1'b0, a2);
        check("b2b_gap", 32'(a2 - last_done_cyc), 32'(GAP * HALF + 1));
        wait_idle();

        // Input activity while busy must be ignored.
        send(16'h3C5A, 1'b0, a1);
        repeat (40) begin
            @(negedge CLK);
            DIN       = 16'hDEAD;
            DIN_VALID = ~DIN_VALID;
            check("busy_ready", 32'(DIN_READY), 32'd0);
        end
        DIN_VALID = 1'b0;
        wait_idle();

        // Abort during data bit 5, then a clean frame.
        send(16'hC3A5, 1'b0, a1);
        repeat (64) @(negedge CLK);
        RST     = 1'b1;
        aborted = 1'b1;
        void'(sb.pop_back());
        @(negedge CLK);
        RST = 1'b0;
        check("abort_outputs", 32'({MANCH, TX_EN, BUSY, DIN_READY, DONE}), 32'b00010);
        send(16'h5A5A, 1'b0, a1);
        wait_idle();

        repeat (4) @(negedge CLK);
        check("idle_level", 32'(idle_bad), 32'd0);
        check("stray_done", 32'(stray_done), 32'd0);
        check("abort_consumed", 32'(aborted), 32'd0);
        check("queue_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/manch_tx.md
Name: manch_tx

Overview:
- Manchester frame transmitter; the transmit end of the link whose receive end is the Manchester decoder (MANCH in, SYNC/SERIALDATA out).
- Accepts one parallel word over a valid/ready handshake.
- Serializes it as: sync violation, data bits MSB first, odd parity bit, then an inter-frame gap.
- Drives MANCH to the line driver or loopback, with TX_EN for driver enable.

Parameters:
- DATA_W, 16, data bits per frame (1..32).
- HALF_BIT_CLKS, 8, CLK cycles per Manchester half-bit (>=2).
- GAP_HALF, 4, idle half-bits inserted after each frame (>=0).
- IDLE_LEVEL, 0, MANCH level while not transmitting.

Ports:
- CLK  input  1  system clock, all logic on posedge.
- RST  input  1  synchronous reset, active-high.
- DIN  input  DATA_W  word to send; sampled on accept.
- DIN_VALID  input  1  DIN holds a word.
- DIN_READY  output  1  block can accept; accept = DIN_VALID & DIN_READY at posedge CLK.
- MANCH  output  1  registered Manchester line output.
- TX_EN  output  1  high from first sync half-bit through the parity bit; low during gap and idle.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle pulse on the last CLK cycle of the parity bit.

Behaviour:
- Reset values: MANCH=IDLE_LEVEL, TX_EN=0, BUSY=0, DONE=0, DIN_READY=1. State=IDLE; counters=0; shift register=0.
- Reset mid-frame aborts the frame. Next cycle the outputs hold their reset values; no DONE is generated.
- Encoding:
  - bit 1 = first half high, second half low.
  - bit 0 = first half low, second half high.
- Sync = 3 half-bits high then 3 half-bits low: 6 half-bits, an intentional Manchester violation.
- Parity = XOR-reduce(DIN) inverted, so total ones over data+parity is odd. Encoded as a normal bit.
- Half-bit timer: counts 0..HALF_BIT_CLKS-1, wraps to 0, and emits tick on the terminal count. The timer is held at 0 in IDLE.
- Half-bit index counter: counts ticks within the current state. Width = clog2(max(6, 2*DATA_W, GAP_HALF)+1).
- States:
  - IDLE: DIN_READY=1. On accept, load shift register=DIN, compute parity, clear counters, go to SYNC. DIN_READY drops in the cycle after accept.
  - SYNC: MANCH=1 for half-bits 0..2 and 0 for half-bits 3..5. After the 6th tick, go to DATA.
  - DATA: MANCH = shreg[DATA_W-1] in the first half-bit and its inverse in the second half-bit. On each second-half tick, shift left 1. After 2*DATA_W ticks, go to PARITY.
  - PARITY: encode the parity bit over 2 half-bits. DONE=1 in the final cycle. Then go to GAP if GAP_HALF>0, else IDLE.
  - GAP: MANCH=IDLE_LEVEL, TX_EN=0, BUSY=1. After GAP_HALF ticks, go to IDLE.
- Timing:
  - MANCH and TX_EN are registered. The first sync level appears on the posedge after the accept edge (latency 1 cycle).
  - Frame length with TX_EN high = (8+2*DATA_W)*HALF_BIT_CLKS cycles exactly.
  - Next accept is possible GAP_HALF*HALF_BIT_CLKS cycles after DONE, plus 1 cycle.
- DIN and DIN_VALID are ignored while BUSY. DIN may change freely after accept.
- MANCH has no glitches at state boundaries: each level is held for exactly HALF_BIT_CLKS cycles.

Decomposition:
- Package manch_pkg holds:
  - state enum {IDLE, SYNC, DATA, PARITY, GAP};
  - SYNC_HALF=6, SYNC_HIGH_HALF=3;
  - encoding constant BIT1_FIRST_HALF=1;
  - function odd_parity(). This package is shared with a future decoder rewrite.
- One sub-module: manch_halfbit_tick (parameter HALF_BIT_CLKS; inputs CLK, RST, EN; output TICK).

Test Plan (DATA_W=16, HALF_BIT_CLKS=4, GAP_HALF=2, IDLE_LEVEL=0):
- Reset release:
  - Stimulus: hold RST 3 cycles, DIN_VALID=0.
  - Response: MANCH=0, TX_EN=0, BUSY=0, DIN_READY=1, DONE=0 throughout.
- Single frame:
  - Stimulus: DIN=16'hA5F0 accepted at cycle 0.
  - Response:
    - cycles 1-12 MANCH=1, cycles 13-24 MANCH=0;
    - bit15=1 gives 4 cycles high then 4 cycles low;
    - the 16 data bits decode back to A5F0;
    - parity bit=1 (8 ones) encoded high then low;
    - TX_EN high exactly 160 cycles;
    - DONE pulses once at cycle 160.
- Parity 0 case:
  - Stimulus: DIN=16'h0001.
  - Response: parity bit=0 (one data one), encoded as 4 cycles low then 4 cycles high.
- Back-to-back:
  - Stimulus: DIN_VALID held high with 16'h1234 then 16'hFFFF.
  - Response: second accept occurs 9 cycles after the first DONE; between frames MANCH=0 and TX_EN=0; second frame parity bit=1.
- Abort:
  - Stimulus: assert RST for 1 cycle during DATA bit 5.
  - Response: next cycle MANCH=0, TX_EN=0, BUSY=0, DIN_READY=1; no DONE; a new frame then sends correctly.
- Busy ignore:
  - Stimulus: during a frame, toggle DIN_VALID with DIN=16'hDEAD.
  - Response: no accept; the in-flight frame bits are unchanged.
